// File: rtl/obuffer_ni.sv
// Network-injector transmit buffer: queues whole flits and serializes them into
// phits toward the router, starting a new flit only when downstream signals Go.
module obuffer_ni #(
  parameter int ID             = 0,
  parameter int FLIT_SIZE      = 64,
  parameter int FLIT_TYPE_SIZE = 2,
  parameter int PHIT_SIZE      = 16,
  parameter int QUEUE_SIZE     = 4
) (
  input  logic                      clk,
  input  logic                      rst_p,
  input  logic [FLIT_SIZE-1:0]      FlitIn,
  input  logic [FLIT_TYPE_SIZE-1:0] FlitTypeIn,
  input  logic                      BroadcastFlitIn,
  input  logic                      ValidIn,
  output logic                      Avail,
  output logic [PHIT_SIZE-1:0]      Flit,
  output logic [FLIT_TYPE_SIZE-1:0] FlitType,
  output logic                      BroadcastFlit,
  output logic                      Valid,
  input  logic                      Go
);

  localparam int NUM_PHITS = FLIT_SIZE / PHIT_SIZE;
  localparam int QW        = (QUEUE_SIZE > 1) ? $clog2(QUEUE_SIZE) : 1;
  localparam int PW        = (NUM_PHITS > 1) ? $clog2(NUM_PHITS) : 1;

  localparam logic [QW:0]   FULL_CNT  = (QW+1)'(QUEUE_SIZE);
  localparam logic [QW:0]   TWO_CNT   = (QW+1)'(2);
  localparam logic [PW-1:0] LAST_PHIT = PW'(NUM_PHITS - 1);

  // Illegal configurations are rejected at elaboration rather than silently mis-serialized.
  if ((ID < 0) || (PHIT_SIZE < 1) || ((FLIT_SIZE % PHIT_SIZE) != 0) ||
      (NUM_PHITS < 1) || (NUM_PHITS > 64) || (QUEUE_SIZE < 2) ||
      ((QUEUE_SIZE & (QUEUE_SIZE - 1)) != 0)) begin : g_param_err
    $error("obuffer_ni: illegal parameter set");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Flits are stored as phit vectors so phit k is element k, LSB phit first.
  logic [NUM_PHITS-1:0][PHIT_SIZE-1:0] data_mem_q  [QUEUE_SIZE];
  logic [FLIT_TYPE_SIZE-1:0]           type_mem_q  [QUEUE_SIZE];
  logic                                bcast_mem_q [QUEUE_SIZE];

  state_e                    state_q, state_d;
  logic [PW-1:0]             phit_q, phit_d;
  logic [QW:0]               count_q, count_d;
  logic [QW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [QW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [PHIT_SIZE-1:0]      flit_q, flit_d;
  logic [FLIT_TYPE_SIZE-1:0] type_q, type_d;
  logic                      bcast_q, bcast_d;
  logic                      valid_q, valid_d;

  logic          avail_s;
  logic          push_s;
  logic          last_phit_s;
  logic          start_s;
  logic [QW-1:0] sel_ptr_s;
  logic [PW-1:0] sel_phit_s;

  assign avail_s     = ~rst_p & (count_q != FULL_CNT);
  assign push_s      = ValidIn & avail_s;
  assign last_phit_s = (state_q == SEND) && (phit_q == LAST_PHIT);
  // A follow-on flit needs a second entry because the current head pops at this same edge.
  assign start_s     = Go & (((state_q == IDLE) && (count_q != '0)) ||
                             (last_phit_s && (count_q >= TWO_CNT)));

  // Next-state, queue bookkeeping and next link phit.
  always_comb begin
    state_d    = state_q;
    phit_d     = phit_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    flit_d     = '0;
    type_d     = '0;
    bcast_d    = 1'b0;
    valid_d    = 1'b0;
    sel_ptr_s  = rd_ptr_q;
    sel_phit_s = phit_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + QW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (last_phit_s) begin
      rd_ptr_d = rd_ptr_q + QW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, last_phit_s})
      2'b10:   count_d = count_q + (QW+1)'(1);
      2'b01:   count_d = count_q - (QW+1)'(1);
      default: count_d = count_q;
    endcase

    if (start_s) begin
      state_d    = SEND;
      phit_d     = '0;
      sel_ptr_s  = (state_q == SEND) ? (rd_ptr_q + QW'(1)) : rd_ptr_q;
      sel_phit_s = '0;
      valid_d    = 1'b1;
    end else if ((state_q == SEND) && !last_phit_s) begin
      state_d    = SEND;
      phit_d     = phit_q + PW'(1);
      sel_phit_s = phit_q + PW'(1);
      valid_d    = 1'b1;
    end else begin
      state_d = IDLE;
      phit_d  = '0;
      valid_d = 1'b0;
    end

    if (valid_d) begin
      flit_d  = data_mem_q[sel_ptr_s][sel_phit_s];
      type_d  = type_mem_q[sel_ptr_s];
      bcast_d = bcast_mem_q[sel_ptr_s];
    end else begin
      flit_d  = '0;
      type_d  = '0;
      bcast_d = 1'b0;
    end
  end

  // Control and link-output registers.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      state_q  <= IDLE;
      phit_q   <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      flit_q   <= '0;
      type_q   <= '0;
      bcast_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phit_q   <= phit_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      flit_q   <= flit_d;
      type_q   <= type_d;
      bcast_q  <= bcast_d;
      valid_q  <= valid_d;
    end
  end

  // Queue storage; push is already blocked during reset through Avail.
  always_ff @(posedge clk) begin
    if (push_s) begin
      data_mem_q[wr_ptr_q]  <= FlitIn;
      type_mem_q[wr_ptr_q]  <= FlitTypeIn;
      bcast_mem_q[wr_ptr_q] <= BroadcastFlitIn;
    end
  end

  assign Avail         = avail_s;
  assign Flit          = flit_q;
  assign FlitType      = type_q;
  assign BroadcastFlit = bcast_q;
  assign Valid         = valid_q;

endmodule

// File: tb/tb_obuffer_ni.sv
// Directed self-checking bench for obuffer_ni at default parameters
// (64-bit flits, 16-bit phits, 4-entry queue).
module tb_obuffer_ni;

  logic        clk = 1'b0;
  logic        rst_p;
  logic [63:0] FlitIn;
  logic [1:0]  FlitTypeIn;
  logic        BroadcastFlitIn;
  logic        ValidIn;
  logic        Avail;
  logic [15:0] Flit;
  logic [1:0]  FlitType;
  logic        BroadcastFlit;
  logic        Valid;
  logic        Go;

  int checks = 0;
  int errors = 0;

  logic [63:0] fl [5];
  logic [1:0]  ft [5];
  logic        fb [5];
  logic [19:0] exp_out;
  logic [19:0] act_out;

  obuffer_ni dut (
    .clk            (clk),
    .rst_p          (rst_p),
    .FlitIn         (FlitIn),
    .FlitTypeIn     (FlitTypeIn),
    .BroadcastFlitIn(BroadcastFlitIn),
    .ValidIn        (ValidIn),
    .Avail          (Avail),
    .Flit           (Flit),
    .FlitType       (FlitType),
    .BroadcastFlit  (BroadcastFlit),
    .Valid          (Valid),
    .Go             (Go)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int idx, input logic v);
    ValidIn         = v;
    FlitIn          = v ? fl[idx] : 64'h0;
    FlitTypeIn      = v ? ft[idx] : 2'b00;
    BroadcastFlitIn = v ? fb[idx] : 1'b0;
  endtask

  task automatic test_reset();
    rst_p = 1'b1; Go = 1'b1; ValidIn = 1'b1;
    FlitIn = 64'hDEAD_BEEF_CAFE_F00D; FlitTypeIn = 2'b11; BroadcastFlitIn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (Avail !== 1'b0) begin errors++; $display("FAIL reset_avail cyc=%0d got %b want 0", i, Avail); end
      checks++;
      if (Valid !== 1'b0) begin errors++; $display("FAIL reset_valid cyc=%0d got %b want 0", i, Valid); end
    end
    rst_p = 1'b0; ValidIn = 1'b0;
    #1;
    checks++;
    if (Avail !== 1'b1) begin errors++; $display("FAIL post_reset_avail got %b want 1", Avail); end
    act_out = {Valid, Flit, FlitType, BroadcastFlit};
    checks++;
    if (act_out !== 20'h0) begin errors++; $display("FAIL post_reset_out got %h want 00000", act_out); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (Valid !== 1'b0) begin errors++; $display("FAIL reset_no_push cyc=%0d got %b want 0", i, Valid); end
    end
  endtask

  task automatic test_single();
    fl[0] = 64'h0123_4567_89AB_CDEF; ft[0] = 2'b01; fb[0] = 1'b1;
    Go = 1'b1;
    tick();
    for (int c = 0; c <= 6; c++) begin
      drive(0, c == 0);
      #1;
      if (c == 0) begin
        checks++;
        if (Avail !== 1'b1) begin errors++; $display("FAIL single_avail got %b want 1", Avail); end
      end
      if (c >= 2 && c <= 5) exp_out = {1'b1, fl[0][16*(c-2) +: 16], ft[0], fb[0]};
      else                  exp_out = 20'h0;
      act_out = {Valid, Flit, FlitType, BroadcastFlit};
      checks++;
      if (act_out !== exp_out) begin errors++; $display("FAIL single cyc=%0d got %h want %h", c, act_out, exp_out); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    fl[0] = 64'h1111_2222_3333_4444; ft[0] = 2'b10; fb[0] = 1'b0;
    fl[1] = 64'h5555_6666_7777_8888; ft[1] = 2'b11; fb[1] = 1'b1;
    fl[2] = 64'h9999_AAAA_BBBB_CCCC; ft[2] = 2'b00; fb[2] = 1'b0;
    Go = 1'b1;
    for (int c = 0; c <= 14; c++) begin
      drive(c, c < 3);
      #1;
      if (c >= 2 && c <= 13) exp_out = {1'b1, fl[(c-2)/4][16*((c-2)%4) +: 16], ft[(c-2)/4], fb[(c-2)/4]};
      else                   exp_out = 20'h0;
      act_out = {Valid, Flit, FlitType, BroadcastFlit};
      checks++;
      if (act_out !== exp_out) begin errors++; $display("FAIL b2b cyc=%0d got %h want %h", c, act_out, exp_out); end
      tick();
    end
  endtask

  task automatic test_stop_go();
    fl[0] = 64'hA0A1_A2A3_A4A5_A6A7; ft[0] = 2'b11; fb[0] = 1'b0;
    for (int c = 0; c <= 15; c++) begin
      Go = (c >= 10);
      drive(0, c == 0);
      #1;
      if (c >= 11 && c <= 14) exp_out = {1'b1, fl[0][16*(c-11) +: 16], ft[0], fb[0]};
      else                    exp_out = 20'h0;
      act_out = {Valid, Flit, FlitType, BroadcastFlit};
      checks++;
      if (act_out !== exp_out) begin errors++; $display("FAIL go_wait cyc=%0d got %h want %h", c, act_out, exp_out); end
      tick();
    end
    fl[0] = 64'hB000_B111_B222_B333; ft[0] = 2'b01; fb[0] = 1'b1;
    fl[1] = 64'hC444_C555_C666_C777; ft[1] = 2'b10; fb[1] = 1'b0;
    for (int c = 0; c <= 13; c++) begin
      Go = !(c >= 3 && c < 8);
      drive(c, c < 2);
      #1;
      if (c >= 2 && c <= 5)      exp_out = {1'b1, fl[0][16*(c-2) +: 16], ft[0], fb[0]};
      else if (c >= 9 && c <= 12) exp_out = {1'b1, fl[1][16*(c-9) +: 16], ft[1], fb[1]};
      else                       exp_out = 20'h0;
      act_out = {Valid, Flit, FlitType, BroadcastFlit};
      checks++;
      if (act_out !== exp_out) begin errors++; $display("FAIL go_drop cyc=%0d got %h want %h", c, act_out, exp_out); end
      tick();
    end
  endtask

  task automatic test_full_queue();
    int nxt;
    nxt = 0;
    for (int i = 0; i < 5; i++) begin
      fl[i] = {4{16'hD000 + 16'(i * 16'h0111)}} ^ {16'h0, 16'h0F00, 16'h00F0, 16'h000F};
      ft[i] = 2'(i);
      fb[i] = i[0];
    end
    for (int c = 0; c <= 27; c++) begin
      Go = (c >= 6);
      drive(nxt, nxt < 5);
      #1;
      if (c <= 11) begin
        checks++;
        if (Avail !== ((c <= 3) || (c == 11))) begin
          errors++; $display("FAIL full_avail cyc=%0d got %b want %b", c, Avail, ((c <= 3) || (c == 11)));
        end
      end
      if (c >= 7 && c <= 26) exp_out = {1'b1, fl[(c-7)/4][16*((c-7)%4) +: 16], ft[(c-7)/4], fb[(c-7)/4]};
      else                   exp_out = 20'h0;
      act_out = {Valid, Flit, FlitType, BroadcastFlit};
      checks++;
      if (act_out !== exp_out) begin errors++; $display("FAIL full_out cyc=%0d got %h want %h", c, act_out, exp_out); end
      if (ValidIn && Avail) nxt++;
      tick();
    end
    checks++;
    if (nxt !== 5) begin errors++; $display("FAIL full_accepted got %0d want 5", nxt); end
  endtask

  task automatic test_reset_mid();
    fl[0] = 64'hE001_E002_E003_E004; ft[0] = 2'b10; fb[0] = 1'b1;
    fl[1] = 64'hF00D_FACE_0BAD_1234; ft[1] = 2'b01; fb[1] = 1'b0;
    Go = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      rst_p = (c == 4);
      drive((c == 10) ? 1 : 0, (c == 0) || (c == 10));
      #1;
      if (c == 4 || c == 5) begin
        checks++;
        if (Avail !== (c == 5)) begin errors++; $display("FAIL midrst_avail cyc=%0d got %b want %b", c, Avail, (c == 5)); end
      end
      if (c >= 2 && c <= 4)       exp_out = {1'b1, fl[0][16*(c-2) +: 16], ft[0], fb[0]};
      else if (c >= 12 && c <= 15) exp_out = {1'b1, fl[1][16*(c-12) +: 16], ft[1], fb[1]};
      else                        exp_out = 20'h0;
      act_out = {Valid, Flit, FlitType, BroadcastFlit};
      checks++;
      if (act_out !== exp_out) begin errors++; $display("FAIL midrst_out cyc=%0d got %h want %h", c, act_out, exp_out); end
      tick();
    end
    rst_p = 1'b0;
  endtask

  initial begin
    rst_p = 1'b1; Go = 1'b0; ValidIn = 1'b0;
    FlitIn = 64'h0; FlitTypeIn = 2'b00; BroadcastFlitIn = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stop_go();
    test_full_queue();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
